// File: rtl/rr_arbiter_hold.sv
// Round-robin arbiter with per-owner hold budget.
// A grant persists until the owner drops its request or the hold budget expires.
module rr_arbiter_hold #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_bin,
    output logic                 gnt_valid,
    output logic                 timeout
);

    localparam int unsigned N_W     = $clog2(N);
    localparam int unsigned CNT_W   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam bit          HOLD_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EN ? (MAX_HOLD - 1) : 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_gnt;
    logic [N_W-1:0]     r_gnt_bin;
    logic               r_gnt_valid;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [N_W-1:0]     r_ptr;

    state_t             w_state_nxt;
    logic [N-1:0]       w_gnt_nxt;
    logic [N_W-1:0]     w_gnt_bin_nxt;
    logic               w_gnt_valid_nxt;
    logic               w_timeout_nxt;
    logic [CNT_W-1:0]   w_hold_cnt_nxt;
    logic [N_W-1:0]     w_ptr_nxt;

    logic [N_W-1:0]     w_owner_next;
    logic [N_W-1:0]     w_search_ptr;
    logic [N-1:0]       w_mask;
    logic [N-1:0]       w_masked;
    logic               w_any;
    logic [N_W-1:0]     w_win_idx;
    logic [N-1:0]       w_win_onehot;
    logic               w_owner_req;
    logic               w_expire;
    logic               w_release;

    function automatic logic [N_W-1:0] lowest_idx(input logic [N-1:0] v);
        logic [N_W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = N_W'(i);
        end
        return idx;
    endfunction

    // Priority starts just past the owner when re-arbitrating, else at ptr.
    assign w_owner_next = (r_gnt_bin == N_W'(N - 1)) ? '0 : r_gnt_bin + N_W'(1);
    assign w_search_ptr = (r_state == S_BUSY) ? w_owner_next : r_ptr;

    // Masked search first; fall back to the unmasked vector to wrap around.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (N_W'(i) >= w_search_ptr);
        end
        w_masked     = req & w_mask;
        w_any        = |req;
        w_win_idx    = (|w_masked) ? lowest_idx(w_masked) : lowest_idx(req);
        w_win_onehot = N'(1) << w_win_idx;
    end

    assign w_owner_req = req[r_gnt_bin];
    assign w_expire    = HOLD_EN && (r_hold_cnt == HOLD_LAST) && w_owner_req;
    assign w_release   = !w_owner_req || w_expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_bin   <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_hold_cnt  <= '0;
            r_ptr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_bin   <= w_gnt_bin_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_bin_nxt   = r_gnt_bin;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_ptr_nxt       = r_ptr;

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_gnt_nxt       = w_win_onehot;
                    w_gnt_bin_nxt   = w_win_idx;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_cnt_nxt  = '0;
                    w_state_nxt     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_release) begin
                    w_ptr_nxt     = w_owner_next;
                    w_timeout_nxt = w_expire;
                    // Hand straight to the next winner so there is no idle bubble.
                    if (w_any) begin
                        w_gnt_nxt       = w_win_onehot;
                        w_gnt_bin_nxt   = w_win_idx;
                        w_gnt_valid_nxt = 1'b1;
                        w_hold_cnt_nxt  = '0;
                    end else begin
                        w_gnt_nxt       = '0;
                        w_gnt_bin_nxt   = '0;
                        w_gnt_valid_nxt = 1'b0;
                        w_hold_cnt_nxt  = '0;
                        w_state_nxt     = S_IDLE;
                    end
                end else if (r_hold_cnt != '1) begin
                    w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_gnt_nxt       = '0;
                w_gnt_bin_nxt   = '0;
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign gnt_bin   = r_gnt_bin;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

    // Structural invariants of the grant outputs.
    a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(r_gnt));
    a_valid:  assert property (@(posedge clk) disable iff (reset) r_gnt_valid == (|r_gnt));
    a_bin:    assert property (@(posedge clk) disable iff (reset)
                               r_gnt == (r_gnt_valid ? (N'(1) << r_gnt_bin) : N'(0)));

endmodule
